mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath. It sequences a single shared ALU, register file and unified memory across fetch/decode/execute/memory/writeback states.
- Drives the 2-bit ALUOp consumed by the ALU_control decoder: 00 add, 01 subtract, 10 decode funct.
- Handshakes with a variable-latency memory through mem_ready.
- Counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
opcode  input  6  instruction register [31:26]
funct  input  6  instruction register [5:0]
mem_ready  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if ALU zero (beq)
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  regfile write data: 1 = MDR, 0 = ALUOut
RegDst  output  1  write register: 1 = rd, 0 = rt
RegWrite  output  1  regfile write enable
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  output  2  to ALU_control
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A
state  output  4  current state encoding (debug)
retire  output  1  one-cycle pulse per completed instruction
illegal_op  output  1  one-cycle pulse on unsupported opcode
inst_count  output  CNT_W  retired-instruction count

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7
  - BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, JR=12
  - Codes 13-15 are unreachable and transition to FETCH.
- Reset:
  - rst sampled high forces state=FETCH and inst_count=0.
  - While rst is high, every control output, retire and illegal_op is 0. The gating is combinational on rst, so it also applies in the cycle reset is asserted.
  - Reset mid-instruction abandons the instruction with no retire.
- Outputs are Moore decodes of state. The only exceptions are IRWrite/PCWrite in FETCH, and retire in MEMWR, which are ANDed with mem_ready. Any output not listed for a state is 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 with funct=001000 -> JR
  - other 000000 -> EXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EX
  - anything else -> FETCH, with illegal_op=1 for this cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD if lw, MEMWR if sw.
- MEMRD: MemRead=1, IorD=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, retire=1. Next is FETCH.
- MEMWR: MemWrite=1, IorD=1, retire=mem_ready. Hold until mem_ready=1, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is RWB.
- RWB: RegDst=1, RegWrite=1, retire=1. Next is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, retire=1. Next is FETCH.
- JUMP: PCWrite=1, PCSource=10, retire=1. Next is FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, retire=1. Next is FETCH.
- JR: PCWrite=1, PCSource=11, retire=1. Next is FETCH.
- Cycle counts with zero-wait memory:
  - lw 5, sw 4, R-type 4, addi 4
  - beq/j/jr 3
  - illegal 2
  - Each mem_ready=0 cycle adds one.
- mem_ready is ignored outside FETCH/MEMRD/MEMWR.
- inst_count increments by 1 on every cycle with retire=1. It wraps modulo 2^CNT_W with no saturation or flag.
- opcode/funct are sampled only in DECODE. The IR is stable there because IRWrite is 0.

Test Plan:
- Reset, then lw with mem_ready=1 always -> states 0,1,2,3,4,0. MemRead=1 in cycles 0 and 3, retire in cycle 4, inst_count=1.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total. IRWrite/PCWrite high only in the single FETCH cycle with mem_ready=1.
- R-type add (funct 100000), then jr (funct 001000) -> add takes EXEC with ALUOp=10 then RWB with RegDst=1. jr takes DECODE->JR with PCSource=11, PCWrite=1. inst_count=2.
- beq then j -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01. JUMP with PCSource=10. Each takes 3 cycles.
- Opcode 111111 -> illegal_op pulse in DECODE, return to FETCH, no retire, inst_count unchanged.
- rst asserted during MEMRD with MemRead=1 -> next cycle state=0, all outputs 0 while rst high, inst_count=0. With CNT_W=4, 16 retirements wrap inst_count to 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences the shared ALU, register file and unified memory through
// fetch/decode/execute/memory/writeback, and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             retire,
    output logic             illegal_op,
    output logic [CNT_W-1:0] inst_count
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDI_EX = 4'd10,
        S_ADDI_WB = 4'd11,
        S_JR      = 4'd12
    } state_t;

    state_t cur_state;
    state_t nxt_state;
    logic   is_store;

    assign state = cur_state;

    // State register; remembers lw vs sw across MEMADR since opcode is only trusted in DECODE
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
            is_store  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) begin
                is_store <= (opcode == OP_SW);
            end
        end
    end

    // Next-state and Moore output decode, all outputs forced low while rst is high
    always_comb begin
        nxt_state   = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        retire      = 1'b0;
        illegal_op  = 1'b0;

        case (cur_state)
            S_FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b01;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                nxt_state = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    nxt_state = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    nxt_state = (funct == FN_JR) ? S_JR : S_EXEC;
                end else if (opcode == OP_BEQ) begin
                    nxt_state = S_BRANCH;
                end else if (opcode == OP_J) begin
                    nxt_state = S_JUMP;
                end else if (opcode == OP_ADDI) begin
                    nxt_state = S_ADDI_EX;
                end else begin
                    illegal_op = 1'b1;
                    nxt_state  = S_FETCH;
                end
            end
            S_MEMADR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = is_store ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nxt_state = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
            end
            S_MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                retire    = mem_ready;
                nxt_state = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA   = 1'b1;
                ALUOp     = 2'b10;
                nxt_state = S_RWB;
            end
            S_RWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                retire   = 1'b1;
            end
            S_ADDI_EX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                nxt_state = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
            end
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
                retire   = 1'b1;
            end
            default: begin
                nxt_state = S_FETCH;
            end
        endcase

        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            MemtoReg    = 1'b0;
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            retire      = 1'b0;
            illegal_op  = 1'b0;
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_count <= '0;
        end else if (retire) begin
            inst_count <= inst_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class
// cycle by cycle and compares state, the full control vector and the count.
module tb_mips_multicycle_ctrl;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             mem_ready;
    logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic             MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, ALUOp, PCSource;
    logic [3:0]       state;
    logic             retire, illegal_op;
    logic [CNT_W-1:0] inst_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .state(state), .retire(retire), .illegal_op(illegal_op),
        .inst_count(inst_count)
    );

    // Layout: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
    //         RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] retire illegal_op
    logic [17:0] ctl;
    assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, retire, illegal_op};

    localparam logic [17:0] C_ZERO    = 18'b0;
    localparam logic [17:0] C_FETCH1  = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_FETCH0  = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] C_DEC_ILL = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] C_MEMRD   = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_MEMWB   = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [17:0] C_MEMWR1  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [17:0] C_MEMWR0  = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] C_EXEC    = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] C_RWB     = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [17:0] C_BRANCH  = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [17:0] C_JUMP    = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [17:0] C_ADDIWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0;
    localparam logic [17:0] C_JR      = 18'b1_0_0_0_0_0_0_0_0_0_00_00_11_1_0;

    // Count one comparison and report it if it disagrees
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive mem_ready, check state/controls mid-cycle, advance to edge+1
    task automatic cyc(input string tag, input logic mr, input logic [3:0] es, input logic [17:0] ec);
        mem_ready = mr;
        #2;
        chk({tag, ".state"}, 32'(state), 32'(es));
        chk({tag, ".ctl"}, 32'(ctl), 32'(ec));
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b1;
        set_ir(6'b100011, 6'b0);
        @(posedge clk);
        #1;
        // Reset: controls gated low even though FETCH would raise them with mem_ready=1
        #2;
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.ctl", 32'(ctl), 32'(C_ZERO));
        chk("rst.cnt", 32'(inst_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lw, zero wait: 0,1,2,3,4
        cyc("lw0.f", 1'b1, 4'd0, C_FETCH1);
        cyc("lw0.d", 1'b1, 4'd1, C_DECODE);
        cyc("lw0.a", 1'b1, 4'd2, C_MEMADR);
        cyc("lw0.r", 1'b1, 4'd3, C_MEMRD);
        cyc("lw0.wb", 1'b1, 4'd4, C_MEMWB);
        chk("lw0.cnt", 32'(inst_count), 32'd1);

        // lw with 3 FETCH waits and 2 MEMRD waits: 10 cycles
        cyc("lw1.f0", 1'b0, 4'd0, C_FETCH0);
        cyc("lw1.f1", 1'b0, 4'd0, C_FETCH0);
        cyc("lw1.f2", 1'b0, 4'd0, C_FETCH0);
        cyc("lw1.f3", 1'b1, 4'd0, C_FETCH1);
        cyc("lw1.d", 1'b0, 4'd1, C_DECODE);
        cyc("lw1.a", 1'b0, 4'd2, C_MEMADR);
        cyc("lw1.r0", 1'b0, 4'd3, C_MEMRD);
        cyc("lw1.r1", 1'b0, 4'd3, C_MEMRD);
        cyc("lw1.r2", 1'b1, 4'd3, C_MEMRD);
        cyc("lw1.wb", 1'b0, 4'd4, C_MEMWB);
        chk("lw1.cnt", 32'(inst_count), 32'd2);

        // R-type add then jr
        set_ir(6'b000000, 6'b100000);
        cyc("add.f", 1'b1, 4'd0, C_FETCH1);
        cyc("add.d", 1'b0, 4'd1, C_DECODE);
        cyc("add.x", 1'b0, 4'd6, C_EXEC);
        cyc("add.wb", 1'b0, 4'd7, C_RWB);
        set_ir(6'b000000, 6'b001000);
        cyc("jr.f", 1'b1, 4'd0, C_FETCH1);
        cyc("jr.d", 1'b1, 4'd1, C_DECODE);
        cyc("jr.x", 1'b1, 4'd12, C_JR);
        chk("jr.cnt", 32'(inst_count), 32'd4);

        // sw with one write wait; retire only when the write completes
        set_ir(6'b101011, 6'b0);
        cyc("sw.f", 1'b1, 4'd0, C_FETCH1);
        cyc("sw.d", 1'b1, 4'd1, C_DECODE);
        set_ir(6'b100011, 6'b0);
        cyc("sw.a", 1'b1, 4'd2, C_MEMADR);
        cyc("sw.w0", 1'b0, 4'd5, C_MEMWR0);
        cyc("sw.w1", 1'b1, 4'd5, C_MEMWR1);
        chk("sw.cnt", 32'(inst_count), 32'd5);

        // addi
        set_ir(6'b001000, 6'b0);
        cyc("addi.f", 1'b1, 4'd0, C_FETCH1);
        cyc("addi.d", 1'b1, 4'd1, C_DECODE);
        cyc("addi.x", 1'b1, 4'd10, C_MEMADR);
        cyc("addi.wb", 1'b1, 4'd11, C_ADDIWB);

        // beq then j
        set_ir(6'b000100, 6'b0);
        cyc("beq.f", 1'b1, 4'd0, C_FETCH1);
        cyc("beq.d", 1'b1, 4'd1, C_DECODE);
        cyc("beq.x", 1'b1, 4'd8, C_BRANCH);
        set_ir(6'b000010, 6'b0);
        cyc("j.f", 1'b1, 4'd0, C_FETCH1);
        cyc("j.d", 1'b1, 4'd1, C_DECODE);
        cyc("j.x", 1'b1, 4'd9, C_JUMP);
        chk("j.cnt", 32'(inst_count), 32'd8);

        // Illegal opcode: pulse in DECODE, back to FETCH, no retire
        set_ir(6'b111111, 6'b0);
        cyc("ill.f", 1'b1, 4'd0, C_FETCH1);
        cyc("ill.d", 1'b1, 4'd1, C_DEC_ILL);
        cyc("ill.back", 1'b0, 4'd0, C_FETCH0);
        chk("ill.cnt", 32'(inst_count), 32'd8);

        // Reset during MEMRD abandons the lw
        set_ir(6'b100011, 6'b0);
        cyc("rlw.f", 1'b1, 4'd0, C_FETCH1);
        cyc("rlw.d", 1'b1, 4'd1, C_DECODE);
        cyc("rlw.a", 1'b1, 4'd2, C_MEMADR);
        cyc("rlw.r", 1'b0, 4'd3, C_MEMRD);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #2;
        chk("rlw.gate", 32'(ctl), 32'(C_ZERO));
        @(posedge clk);
        #3;
        chk("rlw.state", 32'(state), 32'd0);
        chk("rlw.ctl", 32'(ctl), 32'(C_ZERO));
        chk("rlw.cnt", 32'(inst_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 16 jumps wrap the 4-bit counter back to zero
        set_ir(6'b000010, 6'b0);
        for (int i = 0; i < 16; i++) begin
            cyc("wrap.f", 1'b1, 4'd0, C_FETCH1);
            cyc("wrap.d", 1'b1, 4'd1, C_DECODE);
            cyc("wrap.j", 1'b1, 4'd9, C_JUMP);
            if (i == 14) chk("wrap.cnt15", 32'(inst_count), 32'd15);
        end
        chk("wrap.cnt0", 32'(inst_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
